// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and downstream memory request/response signals.
// The arbiter uses the slave modport; the requesters/memory side uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_data;

  logic              ls_req_valid;
  logic [ADDR_W-1:0] ls_req_addr;
  logic              ls_req_wen;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [7:0]        ls_req_wmask;
  logic              ls_req_ready;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_resp_data;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    output ls_req_ready, ls_resp_valid, ls_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    input  ls_req_ready, ls_resp_valid, ls_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) round-robin arbiter onto a single memory port,
// one transaction outstanding at a time.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch it combinationally this cycle
// ISSUE | presenting latched request downstream until mem_req_ready
// WAIT  | waiting for mem_resp_valid, then route response to owner
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  state_t            state, state_nxt;
  logic              last_grant;
  logic              owner;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;

  logic              grant_ls;
  logic              accept;
  logic              if_ready, ls_ready, if_rv, ls_rv, mem_valid;
  logic [DATA_W-1:0] if_rd, ls_rd;

  // On a tie the requester that did not win last time is served.
  assign grant_ls = bus.ls_req_valid && (!bus.if_req_valid || last_grant == GRANT_IF);
  assign accept   = (state == IDLE) && (bus.if_req_valid || bus.ls_req_valid);

  always_comb begin
    state_nxt = state;
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    if_rv     = 1'b0;
    ls_rv     = 1'b0;
    if_rd     = '0;
    ls_rd     = '0;
    mem_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (grant_ls) ls_ready = 1'b1;
          else          if_ready = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (bus.mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid) begin
          if (owner == GRANT_LS) begin
            ls_rv = 1'b1;
            ls_rd = wen_q ? '0 : bus.mem_resp_data;
          end else begin
            if_rv = 1'b1;
            if_rd = bus.mem_resp_data;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Everything is held quiet during the reset cycle, whatever the state register holds.
    if (reset) begin
      if_ready  = 1'b0;
      ls_ready  = 1'b0;
      if_rv     = 1'b0;
      ls_rv     = 1'b0;
      if_rd     = '0;
      ls_rd     = '0;
      mem_valid = 1'b0;
    end
  end

  assign bus.if_req_ready  = if_ready;
  assign bus.ls_req_ready  = ls_ready;
  assign bus.if_resp_valid = if_rv;
  assign bus.if_resp_data  = if_rd;
  assign bus.ls_resp_valid = ls_rv;
  assign bus.ls_resp_data  = ls_rd;
  assign bus.mem_req_valid = mem_valid;
  assign bus.mem_req_addr  = reset ? '0 : addr_q;
  assign bus.mem_req_wen   = reset ? 1'b0 : wen_q;
  assign bus.mem_req_wdata = reset ? '0 : wdata_q;
  assign bus.mem_req_wmask = reset ? 8'h00 : wmask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_LS;
      owner      <= GRANT_IF;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= grant_ls;
        if (grant_ls) begin
          addr_q  <= bus.ls_req_addr;
          wen_q   <= bus.ls_req_wen;
          wdata_q <= bus.ls_req_wdata;
          wmask_q <= bus.ls_req_wmask;
        end else begin
          addr_q  <= bus.if_req_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= 8'h00;
        end
      end
      if (state == WAIT && bus.mem_resp_valid) last_grant <= owner;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   model_last_ls;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_req_addr    = '0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_req_addr    = '0;
    bus.ls_req_wen     = 1'b0;
    bus.ls_req_wdata   = '0;
    bus.ls_req_wmask   = 8'h00;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic chk_quiet_resp(input string tag);
    chk({tag, "_if_rv"}, bus.if_resp_valid, 1'b0);
    chk({tag, "_ls_rv"}, bus.ls_resp_valid, 1'b0);
    chk({tag, "_if_rd"}, bus.if_resp_data, '0);
    chk({tag, "_ls_rd"}, bus.ls_resp_data, '0);
  endtask

  // One full transaction. Requests stay asserted throughout so that ready must
  // be suppressed outside IDLE; stray responses are injected before WAIT.
  task automatic do_txn(input bit iv, input bit lv,
                        input logic [ADDR_W-1:0] if_addr, input logic [ADDR_W-1:0] ls_addr,
                        input bit wen, input logic [DATA_W-1:0] wdata, input logic [7:0] wmask,
                        input int rdly, input int sdly, input logic [DATA_W-1:0] mdata,
                        input bit stray);
    bit win_ls;
    logic [ADDR_W-1:0] e_addr;
    logic              e_wen;
    logic [DATA_W-1:0] e_wdata, e_rdata;
    logic [7:0]        e_wmask;

    win_ls = (iv && lv) ? !model_last_ls : lv;
    e_addr  = win_ls ? ls_addr : if_addr;
    e_wen   = win_ls ? wen : 1'b0;
    e_wdata = win_ls ? wdata : '0;
    e_wmask = win_ls ? wmask : 8'h00;
    e_rdata = (win_ls && wen) ? '0 : mdata;

    @(negedge clk);
    bus.if_req_valid   = iv;
    bus.if_req_addr    = if_addr;
    bus.ls_req_valid   = lv;
    bus.ls_req_addr    = ls_addr;
    bus.ls_req_wen     = wen;
    bus.ls_req_wdata   = wdata;
    bus.ls_req_wmask   = wmask;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = stray;
    bus.mem_resp_data  = 32'h5a5a_0000;
    #1;
    chk("acc_if_ready", bus.if_req_ready, !win_ls);
    chk("acc_ls_ready", bus.ls_req_ready, win_ls);
    chk("acc_mem_valid", bus.mem_req_valid, 1'b0);
    chk_quiet_resp("acc");
    @(posedge clk);

    for (int c = 0; c <= rdly; c++) begin
      @(negedge clk);
      bus.mem_req_ready  = (c == rdly);
      bus.mem_resp_valid = stray && (c == 0);
      #1;
      chk("iss_valid", bus.mem_req_valid, 1'b1);
      chk("iss_addr", bus.mem_req_addr, e_addr);
      chk("iss_wen", bus.mem_req_wen, e_wen);
      chk("iss_wdata", bus.mem_req_wdata, e_wdata);
      chk("iss_wmask", bus.mem_req_wmask, e_wmask);
      chk("iss_readies", {bus.if_req_ready, bus.ls_req_ready}, 2'b00);
      chk_quiet_resp("iss");
      @(posedge clk);
    end

    for (int c = 0; c <= sdly; c++) begin
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = (c == sdly);
      bus.mem_resp_data  = mdata;
      #1;
      chk("wait_mem_valid", bus.mem_req_valid, 1'b0);
      chk("wait_readies", {bus.if_req_ready, bus.ls_req_ready}, 2'b00);
      if (c == sdly) begin
        chk("rsp_if_rv", bus.if_resp_valid, !win_ls);
        chk("rsp_ls_rv", bus.ls_resp_valid, win_ls);
        chk("rsp_if_rd", bus.if_resp_data, win_ls ? '0 : e_rdata);
        chk("rsp_ls_rd", bus.ls_resp_data, win_ls ? e_rdata : '0);
      end else begin
        chk_quiet_resp("wait");
      end
      @(posedge clk);
    end
    model_last_ls = win_ls;

    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_readies", {bus.if_req_ready, bus.ls_req_ready}, 2'b00);
    chk("rst_mem_valid", bus.mem_req_valid, 1'b0);
    chk("rst_mem_addr", bus.mem_req_addr, '0);
    chk_quiet_resp("rst");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    model_last_ls = 1'b1;

    // Fetch-only read with the fastest memory.
    do_txn(1, 0, 32'h8000_0000, '0, 0, '0, 8'h00, 0, 0, 32'h0010_0073, 0);
    // Re-reset so the tie sequence starts from the reset grant history.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_last_ls = 1'b1;
    do_txn(1, 1, 32'h0000_0100, 32'h0000_0200, 0, '0, 8'h00, 0, 0, 32'h1111_1111, 0);
    do_txn(1, 1, 32'h0000_0104, 32'h0000_0204, 0, '0, 8'h00, 0, 0, 32'h2222_2222, 0);
    do_txn(1, 1, 32'h0000_0108, 32'h0000_0208, 0, '0, 8'h00, 0, 0, 32'h3333_3333, 0);
    // Store, then a load held off by five cycles of backpressure.
    do_txn(0, 1, '0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 8'h01, 0, 1, 32'hCAFE_F00D, 1);
    do_txn(0, 1, '0, 32'h8000_1004, 0, 32'h1234_5678, 8'hff, 5, 2, 32'hABCD_0123, 1);

    // Reset while waiting for a response, then a stray response.
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h0000_0400;
    #1;
    chk("r40_acc", bus.if_req_ready, 1'b1);
    @(negedge clk);
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    reset              = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h7777_7777;
    #1;
    chk("r40_rst_mem_valid", bus.mem_req_valid, 1'b0);
    chk_quiet_resp("r40_rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("r40_stray_mem_valid", bus.mem_req_valid, 1'b0);
    chk_quiet_resp("r40_stray");
    @(negedge clk);
    idle_inputs();
    model_last_ls = 1'b1;
    do_txn(1, 1, 32'h0000_0500, 32'h0000_0600, 1, 32'h0F0F_0F0F, 8'h0f, 1, 0, 32'h9999_9999, 0);

    for (int t = 0; t < 60; t++) begin
      bit iv, lv;
      iv = $urandom_range(0, 1);
      lv = $urandom_range(0, 1);
      if (!iv && !lv) iv = 1'b1;
      do_txn(iv, lv, $urandom, $urandom, $urandom_range(0, 1), $urandom,
             8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
